// File: rtl/stack_arb_pkg.sv
// Shared encodings for the stack arbiter: FSM states, op codes, default depth.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/stack_arb_pick.sv
// Two-way picker: turns the request pair and a favour pointer into a one-hot winner.
// Purely combinational; no backpressure, a lone request always wins.
module stack_arb_pick
    import stack_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    // A single active request is already one-hot; only a tie consults the pointer.
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two push/pop requesters onto one stack and tracks its occupancy.
// Latency: req sampled in IDLE, gnt/nack + command next cycle, next sample 3 cycles on.
// Backpressure: requesters hold req until gnt/nack; STACK_ARB_RR_EN selects round-robin.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    op,
    output logic [1:0]    gnt,
    output logic [1:0]    nack,
    output logic          pushenbl,
    output logic          popenbl,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          busy
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t     state, state_nxt;
    logic [1:0] win;
    logic       ptr;
    logic       win_op;
    logic       legal;
    logic [1:0] gnt_nxt, nack_nxt;
    logic       push_nxt, pop_nxt;

`ifdef STACK_ARB_RR_EN
    logic ptr_q;

    // After serving requester 0 favour requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (state == CMD) begin
            ptr_q <= gnt[0] | nack[0];
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    stack_arb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        state_nxt = state;
        gnt_nxt   = 2'b00;
        nack_nxt  = 2'b00;
        push_nxt  = 1'b0;
        pop_nxt   = 1'b0;
        win_op    = win[1] ? op[1] : op[0];
        legal     = (win_op == OP_PUSH) ? (count < FULL_CNT) : (count != '0);
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = CMD;
                    if (legal) begin
                        gnt_nxt  = win;
                        push_nxt = (win_op == OP_PUSH);
                        pop_nxt  = (win_op == OP_POP);
                    end else begin
                        nack_nxt = win;
                    end
                end
            end
            CMD:     state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Commands are only ever high during CMD, so count moves at the end of CMD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            nack     <= 2'b00;
            pushenbl <= 1'b0;
            popenbl  <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            nack     <= nack_nxt;
            pushenbl <= push_nxt;
            popenbl  <= pop_nxt;
            if (pushenbl) begin
                count <= count + CW'(1);
            end else if (popenbl) begin
                count <= count - CW'(1);
            end
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed scenarios then randomized requesters against a transaction model.
module tb_stack_arbiter;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
`ifdef STACK_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    op;
    logic [1:0]    gnt;
    logic [1:0]    nack;
    logic          pushenbl;
    logic          popenbl;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;

    stack_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op       (op),
        .gnt      (gnt),
        .nack     (nack),
        .pushenbl (pushenbl),
        .popenbl  (popenbl),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: occupancy, cycles left before the next sample, favoured requester,
    // and the pulses expected in the cycle after a sample.
    int         m_cnt  = 0;
    int         m_wait = 0;
    int         m_ptr  = 0;
    logic [1:0] e_gnt  = 2'b00;
    logic [1:0] e_nack = 2'b00;
    logic       e_push = 1'b0;
    logic       e_pop  = 1'b0;

    task automatic model_update(input logic rst, input logic [1:0] r, input logic [1:0] o);
        int  w;
        bit  is_push;
        bit  ok;
        if (rst) begin
            m_cnt = 0; m_wait = 0; m_ptr = 0;
            e_gnt = 2'b00; e_nack = 2'b00; e_push = 1'b0; e_pop = 1'b0;
        end else begin
            if (e_push) m_cnt = m_cnt + 1;
            if (e_pop)  m_cnt = m_cnt - 1;
            e_gnt = 2'b00; e_nack = 2'b00; e_push = 1'b0; e_pop = 1'b0;
            if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (r != 2'b00) begin
                if (r == 2'b11) w = RR ? m_ptr : 0;
                else            w = r[1] ? 1 : 0;
                is_push = o[w];
                ok = is_push ? (m_cnt < DEPTH) : (m_cnt > 0);
                if (ok) begin
                    e_gnt[w] = 1'b1;
                    e_push   = is_push;
                    e_pop    = !is_push;
                end else begin
                    e_nack[w] = 1'b1;
                end
                if (RR) m_ptr = (w == 0) ? 1 : 0;
                m_wait = 2;
            end
        end
    endtask

    task automatic compare_all();
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("nack",     32'(nack),     32'(e_nack));
        check("pushenbl", 32'(pushenbl), 32'(e_push));
        check("popenbl",  32'(popenbl),  32'(e_pop));
        check("count",    32'(count),    32'(m_cnt));
        check("full",     32'(full),     32'(m_cnt == DEPTH));
        check("empty",    32'(empty),    32'(m_cnt == 0));
        check("busy",     32'(busy),     32'(m_wait > 0));
        check("excl",     32'(pushenbl & popenbl), 32'(0));
    endtask

    // Inputs change 1 time unit after an edge; outputs are compared at that same point.
    task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] o);
        reset = rst; req = r; op = o;
        @(posedge clk);
        model_update(rst, r, o);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00);
    endtask

    logic [1:0] rq;
    logic [1:0] ro;
    logic [1:0] seen [3];
    int         push_pct;

    initial begin
        reset = 1'b1; req = 2'b00; op = 2'b00;
        #1;

        // Reset state
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00);
        check("rst_count", 32'(count), 32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_empty", 32'(empty), 32'(1));

        // First push after reset
        step(1'b0, 2'b01, 2'b01);
        check("push0_gnt",  32'(gnt),      32'(2'b01));
        check("push0_pen",  32'(pushenbl), 32'(1));
        step(1'b0, 2'b00, 2'b00);
        check("push0_cnt",   32'(count), 32'(1));
        check("push0_empty", 32'(empty), 32'(0));
        idle(2);

        // Pop when empty is rejected
        step(1'b1, 2'b00, 2'b00);
        step(1'b0, 2'b10, 2'b00);
        check("pop_empty_nack", 32'(nack),    32'(2'b10));
        check("pop_empty_pen",  32'(popenbl), 32'(0));
        idle(2);
        check("pop_empty_cnt",  32'(count),   32'(0));

        // Fill to DEPTH then overflow attempt
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 2'b01, 2'b01);
            idle(2);
        end
        check("fill_cnt",  32'(count), 32'(DEPTH));
        check("fill_full", 32'(full),  32'(1));
        step(1'b0, 2'b01, 2'b01);
        check("ovf_nack", 32'(nack),     32'(2'b01));
        check("ovf_pen",  32'(pushenbl), 32'(0));
        idle(2);
        check("ovf_cnt",  32'(count),    32'(DEPTH));

        // Reset during CMD of a push at count 3
        step(1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b10, 2'b10);
            idle(2);
        end
        check("pre_abort_cnt", 32'(count), 32'(3));
        step(1'b0, 2'b01, 2'b01);
        check("abort_cmd_pen", 32'(pushenbl), 32'(1));
        step(1'b1, 2'b00, 2'b00);
        check("abort_cnt",  32'(count),               32'(0));
        check("abort_busy", 32'(busy),                32'(0));
        check("abort_outs", 32'({gnt, nack, pushenbl, popenbl}), 32'(0));
        idle(3);
        check("abort_cnt_hold", 32'(count), 32'(0));

        // Both requesting continuously
        step(1'b1, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b11, 2'b11);
            seen[k] = gnt;
            step(1'b0, 2'b11, 2'b11);
            step(1'b0, 2'b11, 2'b11);
        end
        for (int k = 0; k < 3; k++) begin
            check("both_gnt", 32'(seen[k]), 32'((RR && k == 1) ? 2'b10 : 2'b01));
        end
        idle(2);

        // Randomized requesters that hold req until answered
        rq = 2'b00; ro = 2'b00;
        step(1'b1, 2'b00, 2'b00);
        for (int c = 0; c < 3000; c++) begin
            push_pct = ((c / 400) % 2 == 0) ? 75 : 30;
            if ($urandom_range(599, 0) == 0) begin
                step(1'b1, rq, ro);
            end else begin
                step(1'b0, rq, ro);
            end
            for (int i = 0; i < 2; i++) begin
                if (e_gnt[i] || e_nack[i]) begin
                    rq[i] = 1'b0;
                end else if (!rq[i]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        rq[i] = 1'b1;
                        ro[i] = ($urandom_range(99, 0) < push_pct);
                    end
                end else if (m_wait > 0 && $urandom_range(15, 0) == 0) begin
                    rq[i] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 8, stack entries managed.
REQ-002 SHALL have parameter: CW, 4, count width; SHALL satisfy 2^CW > DEPTH.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port: req  in  2  per-requester request; held high until gnt or nack.
REQ-006 SHALL have port: op  in  2  per-requester operation; 1=push, 0=pop; stable while req high.
REQ-007 SHALL have port: gnt  out  2  one-cycle grant pulse, one-hot or zero.
REQ-008 SHALL have port: nack  out  2  one-cycle reject pulse, one-hot or zero.
REQ-009 SHALL have port: pushenbl  out  1  push command to stack.
REQ-010 SHALL have port: popenbl  out  1  pop command to stack.
REQ-011 SHALL have port: count  out  CW  current occupancy, 0..DEPTH.
REQ-012 SHALL have ports: full, empty  out  1 each  count==DEPTH, count==0, decoded from the count register.
REQ-013 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CMD and SETTLE.
REQ-015 IDLE SHALL sample req; with no req it SHALL stay in IDLE.
REQ-016 In IDLE with any req high, SHALL pick one winner (REQ-024), go to CMD, and register gnt/nack plus command for the CMD cycle.
REQ-017 CMD SHALL last exactly one cycle, then go to SETTLE; SETTLE SHALL last exactly one cycle, then go to IDLE; req SHALL be ignored in CMD and SETTLE.
REQ-018 Legal winner (push with count<DEPTH, or pop with count>0): in CMD, gnt[w]=1 and exactly one of pushenbl/popenbl =1.
REQ-019 Illegal winner (push when full, pop when empty): in CMD, nack[w]=1, pushenbl=popenbl=0, count unchanged.
REQ-020 pushenbl and popenbl SHALL never be high in the same cycle, and SHALL be low outside CMD.
REQ-021 count SHALL change by +1 (push) or -1 (pop) at the end of the CMD cycle, so the new value is visible in SETTLE; count SHALL never wrap.
REQ-022 Latency: req sampled in cycle N -> gnt/nack and command in N+1 -> next sample in N+3; peak throughput is one operation per 3 cycles.
REQ-023 A req dropped before IDLE samples it SHALL have no effect.
REQ-024 Arbitration: if both req are high, the winner is chosen per REQ-029/030; the non-winner's req remains pending.

Reset
REQ-025 reset high SHALL force, on the next rising clk: state=IDLE, count=0, gnt=nack=0, pushenbl=popenbl=0, busy=0, RR pointer=0.
REQ-026 reset asserted in CMD or SETTLE SHALL abort the operation, with no count update after reset; the integrator SHALL reset the stack on the same reset net.
REQ-027 reset SHALL take priority over all other inputs.

Configuration
REQ-028 Macro STACK_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With STACK_ARB_RR_EN defined: round-robin; a 1-bit pointer SHALL flip to favour the other requester after any gnt or nack.
REQ-030 Without STACK_ARB_RR_EN: fixed priority; requester 0 SHALL always win, and the pointer logic SHALL be absent.

Structure
REQ-031 Package stack_arb_pkg SHALL hold the state encodings (IDLE/CMD/SETTLE), OP_PUSH=1 / OP_POP=0, and the default DEPTH.
REQ-032 Sub-module stack_arb_pick SHALL contain the 2-way picker (req, pointer -> one-hot winner); the FSM and count SHALL stay in stack_arbiter.

Verification
REQ-033 After reset: req0=1, op0=push -> gnt=01 and pushenbl=1 one cycle later; count=1 in SETTLE; empty=0.
REQ-034 With count=0: req1=1, op1=pop -> nack=10, popenbl=0, count stays 0.
REQ-035 8 pushes then a 9th push -> count=8, full=1; 9th returns nack with no pushenbl.
REQ-036 Both req high continuously: RR build alternates gnt 01,10,01; non-RR build gives gnt=01 every time; never both command pulses together.
REQ-037 reset during CMD of a push at count=3 -> next cycle count=0, IDLE, all outputs 0.
